// File: rtl/wb_req_arb_n.sv
`default_nettype none
// ============================================================================
// wb_req_arb_n : N-input writeback/release request arbiter with grant lock
//                and a one-entry registered output stage.
// Revision     : 1.0
// ============================================================================
module wb_req_arb_n #(
  parameter int N_IN    = 2,
  parameter int TAG_W   = 20,
  parameter int IDX_W   = 6,
  parameter int PARAM_W = 3,
  parameter int WAY_W   = 8,
  parameter int RR      = 0,
  parameter int BEATS   = 1,
  localparam int SRC_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          in_valid,
  output logic [N_IN-1:0]          in_ready,
  input  logic [N_IN*TAG_W-1:0]    in_tag,
  input  logic [N_IN*IDX_W-1:0]    in_idx,
  input  logic [N_IN*PARAM_W-1:0]  in_param,
  input  logic [N_IN*WAY_W-1:0]    in_way_en,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TAG_W-1:0]         out_tag,
  output logic [IDX_W-1:0]         out_idx,
  output logic [PARAM_W-1:0]       out_param,
  output logic [WAY_W-1:0]         out_way_en,
  output logic [SRC_W-1:0]         out_src,
  output logic                     out_voluntary,
  output logic                     out_last
);

  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic               out_valid_q, out_valid_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [PARAM_W-1:0] out_param_q, out_param_d;
  logic [WAY_W-1:0]   out_way_en_q, out_way_en_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               locked_q, locked_d;
  logic [SRC_W-1:0]   lock_src_q, lock_src_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               can_load;
  logic               xfer;
  logic               last_beat;
  logic               found_lo, found_hi;
  logic [SRC_W-1:0]   sel_lo, sel_hi, sel, grant;
  logic [TAG_W-1:0]   mux_tag;
  logic [IDX_W-1:0]   mux_idx;
  logic [PARAM_W-1:0] mux_param;
  logic [WAY_W-1:0]   mux_way_en;

  // Round-robin is the lowest valid channel above rr_ptr, else the lowest
  // valid channel overall; fixed priority uses the latter only.
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    sel_lo   = '0;
    sel_hi   = '0;
    for (int j = N_IN - 1; j >= 0; j--) begin
      if (in_valid[j]) begin
        sel_lo   = SRC_W'(j);
        found_lo = 1'b1;
        if (SRC_W'(j) > rr_ptr_q) begin
          sel_hi   = SRC_W'(j);
          found_hi = 1'b1;
        end
      end
    end
    if (RR != 0 && found_hi) sel = sel_hi;
    else                     sel = sel_lo;
    grant = locked_q ? lock_src_q : sel;
  end

  assign can_load  = ~out_valid_q | out_ready;
  assign last_beat = (beat_cnt_q == LAST_CNT);

  always_comb begin
    in_ready   = '0;
    mux_tag    = '0;
    mux_idx    = '0;
    mux_param  = '0;
    mux_way_en = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = reset & can_load & (grant == SRC_W'(i)) & (locked_q | in_valid[i]);
      if (grant == SRC_W'(i)) begin
        mux_tag    = in_tag[i*TAG_W +: TAG_W];
        mux_idx    = in_idx[i*IDX_W +: IDX_W];
        mux_param  = in_param[i*PARAM_W +: PARAM_W];
        mux_way_en = in_way_en[i*WAY_W +: WAY_W];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_idx_d    = out_idx_q;
    out_param_d  = out_param_q;
    out_way_en_d = out_way_en_q;
    out_src_d    = out_src_q;
    out_last_d   = out_last_q;
    beat_cnt_d   = beat_cnt_q;
    locked_d     = locked_q;
    lock_src_d   = lock_src_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_tag_d    = mux_tag;
      out_idx_d    = mux_idx;
      out_param_d  = mux_param;
      out_way_en_d = mux_way_en;
      out_src_d    = grant;
      out_last_d   = last_beat;
      beat_cnt_d   = last_beat ? '0 : beat_cnt_q + 1'b1;
      // With a single beat per grant last_beat is always set, so no lock.
      locked_d     = ~last_beat;
      if (!locked_q) begin
        lock_src_d = grant;
        rr_ptr_d   = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      out_idx_q    <= '0;
      out_param_q  <= '0;
      out_way_en_q <= '0;
      out_src_q    <= '0;
      out_last_q   <= 1'b0;
      beat_cnt_q   <= '0;
      locked_q     <= 1'b0;
      lock_src_q   <= '0;
      rr_ptr_q     <= SRC_W'(N_IN - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_idx_q    <= out_idx_d;
      out_param_q  <= out_param_d;
      out_way_en_q <= out_way_en_d;
      out_src_q    <= out_src_d;
      out_last_q   <= out_last_d;
      beat_cnt_q   <= beat_cnt_d;
      locked_q     <= locked_d;
      lock_src_q   <= lock_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_idx       = out_idx_q;
  assign out_param     = out_param_q;
  assign out_way_en    = out_way_en_q;
  assign out_src       = out_src_q;
  assign out_voluntary = |out_src_q;
  assign out_last      = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_req_arb_n.sv
`default_nettype none
// ============================================================================
// tb_wb_req_arb_n : directed bench for wb_req_arb_n in four configurations.
// Revision        : 1.0
// ============================================================================
module tb_wb_req_arb_n;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // a: N_IN=2 RR=0 BEATS=1
  logic [1:0]  a_valid, a_ready;
  logic [39:0] a_tag;
  logic [11:0] a_idx;
  logic [5:0]  a_param;
  logic [15:0] a_way;
  logic        a_oready, a_ov, a_ovol, a_olast;
  logic [19:0] a_otag;
  logic [5:0]  a_oidx;
  logic [2:0]  a_oparam;
  logic [7:0]  a_oway;
  logic [0:0]  a_osrc;

  // r: N_IN=4 RR=1 BEATS=1
  logic [3:0]  r_valid, r_ready;
  logic [79:0] r_tag;
  logic [23:0] r_idx;
  logic [11:0] r_param;
  logic [31:0] r_way;
  logic        r_oready, r_ov, r_ovol, r_olast;
  logic [19:0] r_otag;
  logic [5:0]  r_oidx;
  logic [2:0]  r_oparam;
  logic [7:0]  r_oway;
  logic [1:0]  r_osrc;

  // b: N_IN=4 RR=1 BEATS=4
  logic [3:0]  b_valid, b_ready;
  logic [79:0] b_tag;
  logic [23:0] b_idx;
  logic [11:0] b_param;
  logic [31:0] b_way;
  logic        b_oready, b_ov, b_ovol, b_olast;
  logic [19:0] b_otag;
  logic [5:0]  b_oidx;
  logic [2:0]  b_oparam;
  logic [7:0]  b_oway;
  logic [1:0]  b_osrc;

  // c: N_IN=8 RR=0 BEATS=1
  logic [7:0]   c_valid, c_ready;
  logic [159:0] c_tag;
  logic [47:0]  c_idx;
  logic [23:0]  c_param;
  logic [63:0]  c_way;
  logic         c_oready, c_ov, c_ovol, c_olast;
  logic [19:0]  c_otag;
  logic [5:0]   c_oidx;
  logic [2:0]   c_oparam;
  logic [7:0]   c_oway;
  logic [2:0]   c_osrc;

  wb_req_arb_n #(.N_IN(2), .RR(0), .BEATS(1)) u_a (
    .clock(clock), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
    .in_tag(a_tag), .in_idx(a_idx), .in_param(a_param), .in_way_en(a_way),
    .out_ready(a_oready), .out_valid(a_ov), .out_tag(a_otag), .out_idx(a_oidx),
    .out_param(a_oparam), .out_way_en(a_oway), .out_src(a_osrc),
    .out_voluntary(a_ovol), .out_last(a_olast));

  wb_req_arb_n #(.N_IN(4), .RR(1), .BEATS(1)) u_r (
    .clock(clock), .reset(reset), .in_valid(r_valid), .in_ready(r_ready),
    .in_tag(r_tag), .in_idx(r_idx), .in_param(r_param), .in_way_en(r_way),
    .out_ready(r_oready), .out_valid(r_ov), .out_tag(r_otag), .out_idx(r_oidx),
    .out_param(r_oparam), .out_way_en(r_oway), .out_src(r_osrc),
    .out_voluntary(r_ovol), .out_last(r_olast));

  wb_req_arb_n #(.N_IN(4), .RR(1), .BEATS(4)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_tag(b_tag), .in_idx(b_idx), .in_param(b_param), .in_way_en(b_way),
    .out_ready(b_oready), .out_valid(b_ov), .out_tag(b_otag), .out_idx(b_oidx),
    .out_param(b_oparam), .out_way_en(b_oway), .out_src(b_osrc),
    .out_voluntary(b_ovol), .out_last(b_olast));

  wb_req_arb_n #(.N_IN(8), .RR(0), .BEATS(1)) u_c (
    .clock(clock), .reset(reset), .in_valid(c_valid), .in_ready(c_ready),
    .in_tag(c_tag), .in_idx(c_idx), .in_param(c_param), .in_way_en(c_way),
    .out_ready(c_oready), .out_valid(c_ov), .out_tag(c_otag), .out_idx(c_oidx),
    .out_param(c_oparam), .out_way_en(c_oway), .out_src(c_osrc),
    .out_voluntary(c_ovol), .out_last(c_olast));

  typedef struct {
    int         dut;       // 0=a, 1=c, 2=b
    logic [7:0] valid;
    logic       oready;
    logic [7:0] exp_ready;
    logic       exp_ov;
    logic [2:0] exp_src;
    logic [19:0] exp_tag;
    logic       exp_vol;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic [7:0] v, input logic o, input logic [7:0] er,
                     input logic eov, input logic [2:0] es, input logic [19:0] et,
                     input logic evol, input logic elast);
    vec_t x;
    x = '{d, v, o, er, eov, es, et, evol, elast};
    vecs.push_back(x);
  endtask

  initial begin
    logic [7:0]  act_ready;
    logic        act_ov, act_vol, act_last;
    logic [2:0]  act_src;
    logic [19:0] act_tag;

    a_valid = '0; r_valid = '0; b_valid = '0; c_valid = '0;
    a_oready = 1'b1; r_oready = 1'b1; b_oready = 1'b1; c_oready = 1'b1;
    a_tag = {20'h00BBB, 20'h00AAA};
    a_idx = {6'd2, 6'd1}; a_param = {3'd2, 3'd1}; a_way = {8'h02, 8'h01};
    r_idx = '0; r_param = '0; r_way = '0;
    b_idx = '0; b_param = '0; b_way = '0;
    c_idx = '0; c_param = '0; c_way = '0;
    for (int i = 0; i < 4; i++) begin
      r_tag[i*20 +: 20] = 20'h20000 | 20'(i);
      b_tag[i*20 +: 20] = 20'h30000 | 20'(i);
    end
    for (int i = 0; i < 8; i++) c_tag[i*20 +: 20] = 20'h10000 | 20'(i);

    // fixed priority, two channels
    add(0, 8'h03, 1, 8'h01, 1, 3'd0, 20'h00AAA, 0, 1);
    add(0, 8'h02, 1, 8'h02, 1, 3'd1, 20'h00BBB, 1, 1);
    add(0, 8'h00, 1, 8'h00, 0, 3'd0, 20'h0,     0, 0);
    add(0, 8'h01, 1, 8'h01, 1, 3'd0, 20'h00AAA, 0, 1);
    add(0, 8'h03, 0, 8'h00, 1, 3'd0, 20'h00AAA, 0, 1);
    add(0, 8'h03, 1, 8'h01, 1, 3'd0, 20'h00AAA, 0, 1);
    add(0, 8'h00, 1, 8'h00, 0, 3'd0, 20'h0,     0, 0);
    // fixed priority, eight channels
    add(1, 8'h80, 1, 8'h80, 1, 3'd7, 20'h10007, 1, 1);
    add(1, 8'hC0, 1, 8'h40, 1, 3'd6, 20'h10006, 1, 1);
    add(1, 8'h81, 1, 8'h01, 1, 3'd0, 20'h10000, 0, 1);
    add(1, 8'h00, 1, 8'h00, 0, 3'd0, 20'h0,     0, 0);
    // round-robin 4-beat lock, ch2 gaps mid-burst, ch3 follows
    add(2, 8'h0C, 1, 8'h04, 1, 3'd2, 20'h30002, 1, 0);
    add(2, 8'h0C, 1, 8'h04, 1, 3'd2, 20'h30002, 1, 0);
    add(2, 8'h08, 1, 8'h04, 0, 3'd0, 20'h0,     0, 0);
    add(2, 8'h08, 1, 8'h04, 0, 3'd0, 20'h0,     0, 0);
    add(2, 8'h0C, 1, 8'h04, 1, 3'd2, 20'h30002, 1, 0);
    add(2, 8'h0C, 1, 8'h04, 1, 3'd2, 20'h30002, 1, 1);
    add(2, 8'h0C, 1, 8'h08, 1, 3'd3, 20'h30003, 1, 0);

    // in reset: outputs cleared, no accept even with requests present
    a_valid = 2'b11;
    #12;
    chk("rst_a_ready", 32'(a_ready), 32'h0);
    chk("rst_a_ov", 32'(a_ov), 32'h0);
    chk("rst_b_ov", 32'(b_ov), 32'h0);
    chk("rst_c_src", 32'(c_osrc), 32'h0);
    chk("rst_a_last", 32'(a_olast), 32'h0);
    @(negedge clock);
    a_valid = '0;
    reset = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clock);
      a_valid = '0; b_valid = '0; c_valid = '0;
      case (vecs[k].dut)
        0: begin a_valid = vecs[k].valid[1:0]; a_oready = vecs[k].oready; end
        1: begin c_valid = vecs[k].valid;      c_oready = vecs[k].oready; end
        default: begin b_valid = vecs[k].valid[3:0]; b_oready = vecs[k].oready; end
      endcase
      #1;
      case (vecs[k].dut)
        0: act_ready = {6'b0, a_ready};
        1: act_ready = c_ready;
        default: act_ready = {4'b0, b_ready};
      endcase
      chk($sformatf("vec%0d_in_ready", k), 32'(act_ready), 32'(vecs[k].exp_ready));
      @(posedge clock);
      #1;
      case (vecs[k].dut)
        0: begin act_ov = a_ov; act_src = {2'b0, a_osrc}; act_tag = a_otag; act_vol = a_ovol; act_last = a_olast; end
        1: begin act_ov = c_ov; act_src = c_osrc; act_tag = c_otag; act_vol = c_ovol; act_last = c_olast; end
        default: begin act_ov = b_ov; act_src = {1'b0, b_osrc}; act_tag = b_otag; act_vol = b_ovol; act_last = b_olast; end
      endcase
      chk($sformatf("vec%0d_out_valid", k), 32'(act_ov), 32'(vecs[k].exp_ov));
      if (vecs[k].exp_ov) begin
        chk($sformatf("vec%0d_out_src", k), 32'(act_src), 32'(vecs[k].exp_src));
        chk($sformatf("vec%0d_out_tag", k), 32'(act_tag), 32'(vecs[k].exp_tag));
        chk($sformatf("vec%0d_out_vol", k), 32'(act_vol), 32'(vecs[k].exp_vol));
        chk($sformatf("vec%0d_out_last", k), 32'(act_last), 32'(vecs[k].exp_last));
      end
    end

    // ch3 beat 2 of 4, then asynchronous reset between edges
    @(negedge clock);
    b_valid = 4'b1000;
    #1 chk("mid_ready", 32'(b_ready), 32'h8);
    @(posedge clock);
    #1;
    chk("mid_src", 32'(b_osrc), 32'd3);
    chk("mid_last", 32'(b_olast), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_ov", 32'(b_ov), 32'd0);
    chk("arst_ready", 32'(b_ready), 32'd0);
    chk("arst_src", 32'(b_osrc), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    b_valid = 4'b1001;
    #1 chk("post_rst_ready", 32'(b_ready), 32'h1);
    @(posedge clock);
    #1;
    chk("post_rst_src", 32'(b_osrc), 32'd0);
    chk("post_rst_last", 32'(b_olast), 32'd0);
    chk("post_rst_ov", 32'(b_ov), 32'd1);
    @(negedge clock);
    b_valid = '0;

    // round-robin rotation, one beat per cycle
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      r_valid = 4'hF;
      #1 chk($sformatf("rr%0d_ready", k), 32'(r_ready), 32'(1 << (k % 4)));
      @(posedge clock);
      #1;
      chk($sformatf("rr%0d_src", k), 32'(r_osrc), 32'(k % 4));
      chk($sformatf("rr%0d_ov", k), 32'(r_ov), 32'd1);
    end

    // backpressure: stall holds everything, release drains and loads together
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      r_oready = 1'b0;
      #1 chk($sformatf("bp%0d_ready", k), 32'(r_ready), 32'h0);
      @(posedge clock);
      #1;
      chk($sformatf("bp%0d_ov", k), 32'(r_ov), 32'd1);
      chk($sformatf("bp%0d_src", k), 32'(r_osrc), 32'd3);
      chk($sformatf("bp%0d_tag", k), 32'(r_otag), 32'h20003);
    end
    @(negedge clock);
    r_oready = 1'b1;
    #1 chk("bp_release_ready", 32'(r_ready), 32'h1);
    @(posedge clock);
    #1;
    chk("bp_release_ov", 32'(r_ov), 32'd1);
    chk("bp_release_src", 32'(r_osrc), 32'd0);
    chk("bp_release_tag", 32'(r_otag), 32'h20000);
    @(negedge clock);
    r_valid = '0;
    @(posedge clock);
    #1 chk("rr_drain_ov", 32'(r_ov), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
